cpu_axi_xbar: RTL

Parametrised AXI4-Lite crossbar connecting one CPU-side master port to NUM_SLV slave ports, such as memory, MMIO and UART, selected by per-slave base/mask address decode. It replaces fixed per-peripheral point-to-point wiring between the CPU core and the MPSoC shell. The block buffers AW and W independently and keeps one read and one write outstanding at a time. Unmapped addresses get an internally generated DECERR response.

---
 rtl/cpu_axi_xbar_pkg.sv | 11 +
 rtl/cpu_axi_xbar_dec.sv | 26 ++
 rtl/cpu_axi_xbar.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_axi_xbar_pkg.sv
// Shared constants and FSM state types for the CPU-side AXI4-Lite crossbar.
package cpu_axi_xbar_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA, R_BACK} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_BACK} w_state_t;

endpackage

// File: rtl/cpu_axi_xbar_dec.sv
// Base/mask address decoder: reports whether any slave matches and which one.
module cpu_axi_xbar_dec #(
  parameter int                        NUM_SLV  = 3,
  parameter int                        ADDR_W   = 32,
  parameter int                        SEL_W    = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [SEL_W-1:0]  sel
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_axi_xbar.sv
// AXI4-Lite crossbar: one CPU master to NUM_SLV slaves, one read and one write
// in flight, DECERR generated locally for unmapped addresses.
module cpu_axi_xbar
  import cpu_axi_xbar_pkg::*;
#(
  parameter int                        NUM_SLV  = 3,
  parameter int                        ADDR_W   = 32,
  parameter int                        DATA_W   = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h6000_0000, 32'h4000_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {32'hFFFF_F000, 32'hF000_0000, 32'hC000_0000}
) (
  input  logic                          system_clk,
  input  logic                          system_reset,
  input  logic [ADDR_W-1:0]             s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [DATA_W-1:0]             s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  input  logic [ADDR_W-1:0]             s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [DATA_W-1:0]             s_axi_wdata,
  input  logic [DATA_W/8-1:0]           s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [NUM_SLV*ADDR_W-1:0]     m_axi_araddr,
  output logic [NUM_SLV-1:0]            m_axi_arvalid,
  input  logic [NUM_SLV-1:0]            m_axi_arready,
  input  logic [NUM_SLV*DATA_W-1:0]     m_axi_rdata,
  input  logic [NUM_SLV*2-1:0]          m_axi_rresp,
  input  logic [NUM_SLV-1:0]            m_axi_rvalid,
  output logic [NUM_SLV-1:0]            m_axi_rready,
  output logic [NUM_SLV*ADDR_W-1:0]     m_axi_awaddr,
  output logic [NUM_SLV-1:0]            m_axi_awvalid,
  input  logic [NUM_SLV-1:0]            m_axi_awready,
  output logic [NUM_SLV*DATA_W-1:0]     m_axi_wdata,
  output logic [NUM_SLV*DATA_W/8-1:0]   m_axi_wstrb,
  output logic [NUM_SLV-1:0]            m_axi_wvalid,
  input  logic [NUM_SLV-1:0]            m_axi_wready,
  input  logic [NUM_SLV*2-1:0]          m_axi_bresp,
  input  logic [NUM_SLV-1:0]            m_axi_bvalid,
  output logic [NUM_SLV-1:0]            m_axi_bready,
  output logic [1:0]                    dbg_rd_state,
  output logic [1:0]                    dbg_wr_state
);

  // valid/ready: a beat transfers on a rising edge where both are high; once
  // raised, valid stays high with a stable payload until that edge.

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  function automatic logic [NUM_SLV-1:0] onehot(input logic [SEL_W-1:0] s);
    return NUM_SLV'(1) << s;
  endfunction

  // ---------------- read path ----------------
  r_state_t            r_state, r_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [SEL_W-1:0]    r_sel, r_sel_nxt, rd_sel;
  logic                rd_hit, ar_fire, rd_arready_sel, rd_rvalid_sel;
  logic [DATA_W-1:0]   rd_slv_rdata;
  logic [1:0]          rd_slv_rresp;

  cpu_axi_xbar_dec #(
    .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .SEL_W(SEL_W),
    .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_rd_dec (
    .addr(s_axi_araddr), .hit(rd_hit), .sel(rd_sel)
  );

  assign ar_fire        = s_axi_arvalid & s_axi_arready;
  assign r_sel_nxt      = ar_fire ? rd_sel : r_sel;
  assign rd_arready_sel = |(m_axi_arready & onehot(r_sel));
  assign rd_rvalid_sel  = |(m_axi_rvalid & onehot(r_sel));

  always_comb begin
    rd_slv_rdata = '0;
    rd_slv_rresp = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_sel == SEL_W'(i)) begin
        rd_slv_rdata = m_axi_rdata[i*DATA_W +: DATA_W];
        rd_slv_rresp = m_axi_rresp[i*2 +: 2];
      end
    end
  end

  always_comb begin
    r_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_nxt = rd_hit ? R_REQ : R_BACK;
      R_REQ:   if (rd_arready_sel) r_nxt = R_DATA;
      R_DATA:  if (rd_rvalid_sel) r_nxt = R_BACK;
      R_BACK:  if (s_axi_rready) r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (system_reset) begin
      r_state       <= R_IDLE;
      r_addr        <= '0;
      r_sel         <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      m_axi_arvalid <= '0;
      m_axi_rready  <= '0;
    end else begin
      r_state <= r_nxt;
      if (ar_fire) begin
        r_addr <= s_axi_araddr;
        r_sel  <= rd_sel;
        if (!rd_hit) begin
          s_axi_rdata <= '0;
          s_axi_rresp <= DECERR;
        end
      end
      if (r_state == R_DATA && rd_rvalid_sel) begin
        s_axi_rdata <= rd_slv_rdata;
        s_axi_rresp <= rd_slv_rresp;
      end
      s_axi_arready <= (r_nxt == R_IDLE);
      s_axi_rvalid  <= (r_nxt == R_BACK);
      m_axi_arvalid <= (r_nxt == R_REQ)  ? onehot(r_sel_nxt) : '0;
      m_axi_rready  <= (r_nxt == R_DATA) ? onehot(r_sel_nxt) : '0;
    end
  end

  assign m_axi_araddr = {NUM_SLV{r_addr}};
  assign dbg_rd_state = r_state;

  // ---------------- write path ----------------
  w_state_t            w_state, w_nxt;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic [SEL_W-1:0]    w_sel, w_sel_nxt, wr_sel;
  logic                w_hit, wr_hit, w_hit_cur;
  logic                aw_held, w_held, aw_held_nxt, w_held_nxt;
  logic                aw_pend, w_pend, aw_pend_nxt, w_pend_nxt;
  logic                aw_fire, wd_fire, aw_got, w_got, aw_acc, wd_acc, wr_bvalid_sel;
  logic [1:0]          wr_slv_bresp;

  cpu_axi_xbar_dec #(
    .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .SEL_W(SEL_W),
    .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) u_wr_dec (
    .addr(s_axi_awaddr), .hit(wr_hit), .sel(wr_sel)
  );

  assign aw_fire       = s_axi_awvalid & s_axi_awready;
  assign wd_fire       = s_axi_wvalid & s_axi_wready;
  assign aw_got        = aw_held | aw_fire;
  assign w_got         = w_held | wd_fire;
  assign w_hit_cur     = aw_fire ? wr_hit : w_hit;
  assign w_sel_nxt     = aw_fire ? wr_sel : w_sel;
  assign aw_acc        = aw_pend & |(m_axi_awready & onehot(w_sel));
  assign wd_acc        = w_pend & |(m_axi_wready & onehot(w_sel));
  assign wr_bvalid_sel = |(m_axi_bvalid & onehot(w_sel));

  always_comb begin
    wr_slv_bresp = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_sel == SEL_W'(i)) wr_slv_bresp = m_axi_bresp[i*2 +: 2];
    end
  end

  always_comb begin
    w_nxt       = w_state;
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    aw_pend_nxt = aw_pend;
    w_pend_nxt  = w_pend;
    case (w_state)
      W_IDLE: begin
        aw_held_nxt = aw_got;
        w_held_nxt  = w_got;
        if (aw_got && w_got) begin
          aw_held_nxt = 1'b0;
          w_held_nxt  = 1'b0;
          if (w_hit_cur) begin
            w_nxt       = W_REQ;
            aw_pend_nxt = 1'b1;
            w_pend_nxt  = 1'b1;
          end else begin
            w_nxt = W_BACK;
          end
        end
      end
      W_REQ: begin
        if (aw_acc) aw_pend_nxt = 1'b0;
        if (wd_acc) w_pend_nxt = 1'b0;
        if ((!aw_pend || aw_acc) && (!w_pend || wd_acc)) w_nxt = W_RESP;
      end
      W_RESP:  if (wr_bvalid_sel) w_nxt = W_BACK;
      W_BACK:  if (s_axi_bready) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (system_reset) begin
      w_state       <= W_IDLE;
      w_addr        <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      w_sel         <= '0;
      w_hit         <= 1'b0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_pend       <= 1'b0;
      w_pend        <= 1'b0;
      s_axi_bresp   <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      m_axi_awvalid <= '0;
      m_axi_wvalid  <= '0;
      m_axi_bready  <= '0;
    end else begin
      w_state <= w_nxt;
      aw_held <= aw_held_nxt;
      w_held  <= w_held_nxt;
      aw_pend <= aw_pend_nxt;
      w_pend  <= w_pend_nxt;
      if (aw_fire) begin
        w_addr <= s_axi_awaddr;
        w_sel  <= wr_sel;
        w_hit  <= wr_hit;
      end
      if (wd_fire) begin
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (w_state == W_IDLE && w_nxt == W_BACK) s_axi_bresp <= DECERR;
      if (w_state == W_RESP && wr_bvalid_sel)   s_axi_bresp <= wr_slv_bresp;
      s_axi_awready <= (w_nxt == W_IDLE) && !aw_held_nxt;
      s_axi_wready  <= (w_nxt == W_IDLE) && !w_held_nxt;
      s_axi_bvalid  <= (w_nxt == W_BACK);
      m_axi_awvalid <= (w_nxt == W_REQ && aw_pend_nxt) ? onehot(w_sel_nxt) : '0;
      m_axi_wvalid  <= (w_nxt == W_REQ && w_pend_nxt)  ? onehot(w_sel_nxt) : '0;
      m_axi_bready  <= (w_nxt == W_RESP) ? onehot(w_sel_nxt) : '0;
    end
  end

  assign m_axi_awaddr = {NUM_SLV{w_addr}};
  assign m_axi_wdata  = {NUM_SLV{w_data}};
  assign m_axi_wstrb  = {NUM_SLV{w_strb}};
  assign dbg_wr_state = w_state;

endmodule
